conv_window_sequencer: RTL and testbench

- Read-side controller for the CNN image memory (dual 5-bit row/column address, 8-bit data, synchronous 1-cycle read).
- On start, walks every KxK convolution window, stride 1, and streams pixels to the MAC array through a valid/ready handshake.
- Arbitrates the memory port between the host loader (idle only) and its own read sequence.

---
 rtl/conv_window_sequencer.sv | 241 ++++++++++++++++++++++++
 tb/tb_conv_window_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_sequencer.sv
// Walks every KxK stride-1 window of the image memory and streams tagged pixels over valid/ready.
// Optional build macro: CONV_ZERO_PAD_EN selects "same" zero padding of (K-1)/2 on each border.
module conv_window_sequencer #(
  parameter  int ADDR_W = 5,
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 28,
  parameter  int IMG_H  = 28,
  parameter  int K      = 3,
  localparam int TAP_W  = (K * K > 1) ? $clog2(K * K) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr1,
  input  logic [ADDR_W-1:0] host_addr2,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_err,
  output logic [ADDR_W-1:0] mem_addr1,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              win_last,
  output logic              frame_last
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
`ifdef CONV_ZERO_PAD_EN
  localparam int PAD      = (K - 1) / 2;
  localparam int ROW_LAST = IMG_H - 1;
  localparam int COL_LAST = IMG_W - 1;
  localparam int CW       = ADDR_W + 2;
`else
  localparam int ROW_LAST = IMG_H - K;
  localparam int COL_LAST = IMG_W - K;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TAP_W-1:0]  tap;
    logic              win_last;
    logic              frame_last;
  } pix_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] win_row, win_col;
  logic [KW-1:0]     ky, kx;
  logic [ADDR_W-1:0] cur_addr1, cur_addr2;
  logic [ADDR_W-1:0] addr1_q, addr2_q;
  logic              kx_last, ky_last, col_last, row_last;
  logic              tap_win_last, tap_frame_last;
  logic [TAP_W-1:0]  tap_cur;

  // Buffer: 2-entry FIFO plus the read currently returning from memory.
  pix_t              fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_count;
  logic              in_flight;
  logic [TAP_W-1:0]  tag_tap;
  logic              tag_win_last, tag_frame_last;
  logic [1:0]        occ, occ_left;
  logic              pop, push, fifo_pop, issue;
  pix_t              fly, head;

  assign kx_last        = (kx == KW'(K - 1));
  assign ky_last        = (ky == KW'(K - 1));
  assign col_last       = (win_col == ADDR_W'(COL_LAST));
  assign row_last       = (win_row == ADDR_W'(ROW_LAST));
  assign tap_win_last   = kx_last && ky_last;
  assign tap_frame_last = tap_win_last && col_last && row_last;
  assign tap_cur        = TAP_W'(ky) * TAP_W'(K) + TAP_W'(kx);

`ifdef CONV_ZERO_PAD_EN
  logic [CW-1:0] row_sum, col_sum;
  logic          pad_tap, tag_pad;

  // Window origin sits PAD pixels up/left of the image; out-of-image taps read nothing.
  assign row_sum   = CW'(win_row) + CW'(ky);
  assign col_sum   = CW'(win_col) + CW'(kx);
  assign pad_tap   = (row_sum < CW'(PAD)) || (row_sum >= CW'(IMG_H + PAD)) ||
                     (col_sum < CW'(PAD)) || (col_sum >= CW'(IMG_W + PAD));
  assign cur_addr1 = ADDR_W'(row_sum - CW'(PAD));
  assign cur_addr2 = ADDR_W'(col_sum - CW'(PAD));
`else
  assign cur_addr1 = win_row + ADDR_W'(ky);
  assign cur_addr2 = win_col + ADDR_W'(kx);
`endif

  // Occupancy after this cycle's pop decides whether another read fits.
  assign occ       = fifo_count + {1'b0, in_flight};
  assign pix_valid = (occ != 2'd0);
  assign pop       = pix_valid && pix_ready;
  assign occ_left  = occ - {1'b0, pop};
  assign issue     = (state == S_RUN) && (occ_left < 2'd2);
  assign fifo_pop  = pop && (fifo_count != 2'd0);
  assign push      = in_flight && !(pop && (fifo_count == 2'd0));

  always_comb begin
`ifdef CONV_ZERO_PAD_EN
    fly.data = tag_pad ? '0 : mem_rdata;
`else
    fly.data = mem_rdata;
`endif
    fly.tap        = tag_tap;
    fly.win_last   = tag_win_last;
    fly.frame_last = tag_frame_last;
  end

  // Oldest entry first: the FIFO head, else the read landing this cycle.
  assign head       = (fifo_count != 2'd0) ? fifo_mem[rd_ptr] : fly;
  assign pix_data   = pix_valid ? head.data       : '0;
  assign tap_idx    = pix_valid ? head.tap        : '0;
  assign win_last   = pix_valid ? head.win_last   : 1'b0;
  assign frame_last = pix_valid ? head.frame_last : 1'b0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      host_err <= 1'b0;
      addr1_q  <= '0;
      addr2_q  <= '0;
    end else begin
      state    <= state_nxt;
      host_err <= host_wr && (state != S_IDLE);
      if (state == S_RUN) begin
        addr1_q <= mem_addr1;
        addr2_q <= mem_addr2;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = (state != S_IDLE);
    done      = (state == S_DONE);
    mem_wr    = 1'b0;
    mem_wdata = '0;
    mem_addr1 = addr1_q;
    mem_addr2 = addr2_q;
    case (state)
      S_IDLE: begin
        mem_wr    = host_wr;
        mem_wdata = host_wdata;
        mem_addr1 = host_addr1;
        mem_addr2 = host_addr2;
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
`ifdef CONV_ZERO_PAD_EN
        if (!pad_tap) begin
          mem_addr1 = cur_addr1;
          mem_addr2 = cur_addr2;
        end
`else
        mem_addr1 = cur_addr1;
        mem_addr2 = cur_addr2;
`endif
        if (issue && tap_frame_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (occ_left == 2'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Raster walk, kx fastest; all counters wrap back to 0 after the last tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_row <= '0;
      win_col <= '0;
      ky      <= '0;
      kx      <= '0;
    end else if (issue) begin
      if (kx_last) begin
        kx <= '0;
        if (ky_last) begin
          ky <= '0;
          if (col_last) begin
            win_col <= '0;
            win_row <= row_last ? '0 : win_row + ADDR_W'(1);
          end else begin
            win_col <= win_col + ADDR_W'(1);
          end
        end else begin
          ky <= ky + KW'(1);
        end
      end else begin
        kx <= kx + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      fifo_count     <= 2'd0;
      in_flight      <= 1'b0;
      tag_tap        <= '0;
      tag_win_last   <= 1'b0;
      tag_frame_last <= 1'b0;
`ifdef CONV_ZERO_PAD_EN
      tag_pad        <= 1'b0;
`endif
    end else begin
      if (push)     wr_ptr <= ~wr_ptr;
      if (fifo_pop) rd_ptr <= ~rd_ptr;
      case ({push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
      in_flight <= issue;
      if (issue) begin
        tag_tap        <= tap_cur;
        tag_win_last   <= tap_win_last;
        tag_frame_last <= tap_frame_last;
`ifdef CONV_ZERO_PAD_EN
        tag_pad        <= pad_tap;
`endif
      end
    end
  end

  // NOTE: FIFO storage is not reset; fifo_count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= fly;
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer on a 4x4 image with K=3: host load, streaming under
// several pix_ready patterns, host collisions and mid-frame reset, against a window-walk model.
module tb_conv_window_sequencer;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int IH = 4;
  localparam int KK = 3;
  localparam int TW = 4;
`ifdef CONV_ZERO_PAD_EN
  localparam int PADN = (KK - 1) / 2;
  localparam int NWR  = IH;
  localparam int NWC  = IW;
  int win0_lit [9] = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
  localparam int LAST_PIX = 0;
`else
  localparam int PADN = 0;
  localparam int NWR  = IH - KK + 1;
  localparam int NWC  = IW - KK + 1;
  int win0_lit [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
  localparam int LAST_PIX = 15;
`endif
  localparam int FRAME_LEN = NWR * NWC * KK * KK;

  logic          clk, rst, start, busy, done;
  logic          host_wr, host_err;
  logic [AW-1:0] host_addr1, host_addr2, mem_addr1, mem_addr2;
  logic [DW-1:0] host_wdata, mem_wdata, mem_rdata, pix_data;
  logic          mem_wr, pix_valid, pix_ready, win_last, frame_last;
  logic [TW-1:0] tap_idx;

  conv_window_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .K(KK)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .host_wr(host_wr), .host_addr1(host_addr1), .host_addr2(host_addr2),
    .host_wdata(host_wdata), .host_err(host_err),
    .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .tap_idx(tap_idx), .win_last(win_last), .frame_last(frame_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image memory: synchronous write, registered 1-cycle read.
  logic [DW-1:0] mem [0:31][0:31];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr1][mem_addr2] <= mem_wdata;
    mem_rdata <= mem[mem_addr1][mem_addr2];
  end

  int n_err = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    logic [TW-1:0] tap;
    logic          wl;
    logic          fl;
  } exp_t;

  int   ref_img [IH][IW];
  exp_t exp_q [$];

  // Expected stream: every window in raster order, every tap in raster order.
  task automatic fill_expected();
    exp_t e2;
    exp_q.delete();
    for (int wr = 0; wr < NWR; wr++)
      for (int wc = 0; wc < NWC; wc++)
        for (int ky = 0; ky < KK; ky++)
          for (int kx = 0; kx < KK; kx++) begin
            int r, c;
            r = wr + ky - PADN;
            c = wc + kx - PADN;
            if (r >= 0 && r < IH && c >= 0 && c < IW) e2.d = 8'(ref_img[r][c]);
            else e2.d = 8'd0;
            e2.tap = 4'(ky * KK + kx);
            e2.wl  = (ky == KK - 1) && (kx == KK - 1);
            e2.fl  = e2.wl && (wr == NWR - 1) && (wc == NWC - 1);
            exp_q.push_back(e2);
          end
  endtask

  // Compare process
  logic          mon_en = 1'b0;
  int            cyc = 0;
  int            n_rx, first_hs, last_hs;
  logic          stall_q, done_due, done_seen, rx_fl_last;
  logic [14:0]   held, out_vec;
  logic [DW-1:0] rx_data [$];
  exp_t          e_mon;

  assign out_vec = {pix_valid, pix_data, tap_idx, win_last, frame_last};

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("done_timing", 32'(done), 32'(done_due));
      if (done) done_seen = 1'b1;
      done_due = 1'b0;
      if (stall_q) check("stall_hold", 32'(out_vec), 32'(held));
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 32'(pix_data), 32'hFFFF_FFFF);
        end else begin
          e_mon = exp_q.pop_front();
          check("pixel", 32'({pix_data, tap_idx, win_last, frame_last}), 32'(e_mon));
          rx_data.push_back(pix_data);
          rx_fl_last = frame_last;
          if (n_rx == 0) first_hs = cyc;
          last_hs = cyc;
          n_rx++;
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
      stall_q = pix_valid && !pix_ready;
      held    = out_vec;
    end
  end

  function automatic logic ready_pat(input int mode, input int k);
    if (mode == 0) return 1'b1;
    return !((k % 4) == 1 || (k % 4) == 2);
  endfunction

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating.
  // inject_at >= 0: host write at that cycle; abort_after > 0: reset after that many pixels.
  task automatic run_frame(input int mode, input int inject_at, input int abort_after);
    int k;
    fill_expected();
    n_rx = 0; rx_data.delete(); stall_q = 1'b0; done_due = 1'b0; done_seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; pix_ready = ready_pat(mode, 0); mon_en = 1'b1;
    @(negedge clk);
    check("busy_in_start_cycle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; pix_ready = ready_pat(mode, 1);
    @(negedge clk);
    check("valid_low_first_run_cycle", 32'(pix_valid), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    k = 2;
    while (!done_seen && k < 2000) begin
      @(posedge clk); #1;
      pix_ready = ready_pat(mode, k);
      host_wr   = (k == inject_at);
      host_addr1 = '0; host_addr2 = '0;
      host_wdata = host_wr ? 8'hAA : 8'h00;
      if (abort_after > 0 && n_rx >= abort_after) begin
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(pix_valid), 32'd0);
        check("abort_count", 32'(n_rx), 32'(abort_after));
        mon_en = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("no_done_after_abort", 32'(done), 32'd0);
        end
        return;
      end
      @(negedge clk);
      if (k == 2) check("first_valid_latency", 32'(pix_valid), 32'd1);
      check("mem_wr_blocked", 32'(mem_wr), 32'd0);
      if (inject_at >= 0) check("host_err", 32'(host_err), 32'(k == inject_at + 1));
      k++;
    end
    check("done_seen", 32'(done_seen), 32'd1);
    check("pixel_count", 32'(n_rx), 32'(FRAME_LEN));
    check("expected_drained", 32'(exp_q.size()), 32'd0);
    if (mode == 0) check("back_to_back", 32'(last_hs - first_hs), 32'(FRAME_LEN - 1));
    @(posedge clk); #1;
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    mon_en = 1'b0;
  endtask

  task automatic pin_literals();
    for (int i = 0; i < 9; i++) check("window0_literal", 32'(rx_data[i]), 32'(win0_lit[i]));
    check("last_pixel_literal", 32'(rx_data[FRAME_LEN - 1]), 32'(LAST_PIX));
    check("last_frame_last", 32'(rx_fl_last), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    host_wr = 1'b0; host_addr1 = '0; host_addr2 = '0; host_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'({busy, done, host_err, mem_wr, pix_valid, win_last, frame_last}), 32'd0);
    check("rst_data", 32'({mem_addr1, mem_addr2, pix_data, tap_idx}), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_state", 32'({busy, done, host_err, pix_valid, tap_idx}), 32'd0);

    // Host load: pixel(r,c) = 4r + c.
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        @(posedge clk); #1;
        host_wr = 1'b1; host_addr1 = 5'(r); host_addr2 = 5'(c); host_wdata = 8'(4 * r + c);
        ref_img[r][c] = 4 * r + c;
        @(negedge clk);
        check("host_mirror", 32'({mem_wr, mem_addr1, mem_addr2, mem_wdata}),
              32'({1'b1, 5'(r), 5'(c), 8'(4 * r + c)}));
        check("host_err_idle", 32'(host_err), 32'd0);
      end
    @(posedge clk); #1 host_wr = 1'b0;
    @(negedge clk);
    check("host_err_idle_end", 32'(host_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      host_addr1 = 5'(i); host_addr2 = 5'(3 - i);
      @(negedge clk);
      @(negedge clk);
      check("read_back", 32'(mem_rdata), 32'(4 * i + 3 - i));
    end
    @(posedge clk); #1 host_addr1 = '0; host_addr2 = '0;

    run_frame(0, -1, 0);
    pin_literals();
    run_frame(1, -1, 0);
    pin_literals();
    run_frame(0, 5, 0);
    run_frame(0, -1, 0);
    check("mem_unchanged_after_host_err", 32'(rx_data[0]), 32'(win0_lit[0]));
    run_frame(0, -1, 10);
    run_frame(0, -1, 0);
    pin_literals();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
